spin_sequencer: RTL
===================

// Module: spin_sequencer
// PURPOSE
//  Two-requester front end for the spinner rotator (4-bit rotate-right by amount 0..3, two-stage, with spin recirculation).
//  Round-robin arbitrates requests carrying a 4-bit word and a rotate count, then drives spinner din/amount/spin.
//  Splits the count into passes of at most PASS_MAX steps, recirculating through the spinner, and returns the result
//  with requester id on a valid/ready response port. One request is in flight at a time.
// PARAMETERS
//  PASS_MAX  3  max rotate steps per spinner pass; legal 1..3
//  CNT_W     4  width of request rotate count
// PORTS
//  clock        in   1      single clock, all state on posedge
//  reset        in   1      synchronous, active-high
//  req0_valid   in   1      requester 0 has a request
//  req0_ready   out  1      requester 0 request accepted this cycle when valid&ready
//  req0_data    in   4      word to rotate
//  req0_count   in   CNT_W  rotate-right step count, 0..2^CNT_W-1
//  req1_valid/req1_ready/req1_data/req1_count: same for requester 1
//  rsp_valid    out  1      result available
//  rsp_ready    in   1      consumer takes result when valid&ready
//  rsp_data     out  4      rotated word
//  rsp_id       out  1      requester that owns rsp_data
//  sp_din       out  4      to spinner din
//  sp_amount    out  2      to spinner amount
//  sp_spin      out  1      to spinner spin
//  sp_dout      in   4      from spinner dout
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Spinner contract (cycle n = interval after edge n):
//   inr(n+1)=spl(n)?dout(n):din(n); dout(n+1)=rotr(inr(n),amount(n)); spl(n+1)=spin(n).
//  Reset: state=IDLE, rr pointer=req0, rsp_valid=0, rsp_data=0, rsp_id=0, sp_din=0, sp_amount=0, sp_spin=0, busy=0.
//   Reset asserted mid-operation aborts the request; no response is produced. Spinner internals are ignored because
//   sp_spin=0 in IDLE.
//  Arbiter: only in IDLE. If one valid, grant it. If both valid, grant the rr pointer's side. The pointer moves to the
//   other requester after each accept. reqX_ready = IDLE & grantX (combinational). Never both ready.
//  Accept latches data, id and remaining=count, count 0 included.
//  Passes: P = max(1, ceil(count/PASS_MAX)). Each pass amount = min(remaining, PASS_MAX); a zero count gives one pass of amount 0.
//  FSM (accept at end of cycle k):
//   IDLE -> LOAD on accept.
//   LOAD (cycle k+1): sp_din=data, sp_spin=0 -> ROT.
//   ROT: sp_amount=this pass amount; sp_spin=1 if another pass follows, else 0. remaining -= amount -> RES.
//   RES: sp_dout holds this pass result; sp_spin=0. If remaining>0 -> ROT. Else capture sp_dout into rsp_data,
//    set rsp_valid and rsp_id -> RSP.
//   RSP: hold rsp_* stable while rsp_ready=0. On rsp_ready -> IDLE, rsp_valid=0 next cycle.
//  Latency: final RES in cycle k+1+2P; rsp_valid first high in cycle k+2+2P. No request is accepted in RSP, so the
//   earliest back-to-back accept is the IDLE cycle after the response handshake.
//  sp_amount=0 and sp_din held at last value outside ROT/LOAD. sp_spin is high only in non-final ROT.
//  Width: remaining is CNT_W bits and never underflows. Rotate is modulo 4; count 4 yields the input word.
//  Requests deasserted before acceptance are simply not granted. Data/count are sampled only at accept.
// TESTING
//  1. req0 data=4'b0001 count=1, rsp_ready=1 -> rsp_valid in cycle k+4, rsp_data=4'b1000, rsp_id=0.
//  2. req1 data=4'b0011 count=5 (PASS_MAX=3) -> passes 3,2; sp_spin=1 only in first ROT; rsp_data=4'b1001 at k+6, rsp_id=1.
//  3. req0 data=4'b1010 count=0 -> single pass amount 0, rsp_data=4'b1010 at k+4.
//  4. both valid continuously from reset -> grants alternate 0,1,0,1; never both ready.
//  5. rsp_ready low 3 cycles -> rsp_valid/data/id stable, no new accept; accept resumes in the IDLE cycle after handshake.
//  6. reset asserted in second ROT of count=9 -> next cycle IDLE, all outputs at reset values; next request gives a correct result.

Source files
------------

// File: rtl/spin_sequencer.sv
// -----------------------------------------------------------------------------
// spin_sequencer
//   Two-requester front end for the spinner rotator. The spinner is a two-stage
//   4-bit rotate-right unit (amount 0..3) that can recirculate its own output
//   back into its input register when spin is set.
//
//   A round-robin arbiter picks one of two requesters, each carrying a 4-bit
//   word and a rotate-right count. The count is broken into passes of at most
//   PASS_MAX steps. Each pass goes through the spinner, and later passes
//   recirculate the previous result. The final word is returned together with
//   the id of the requester that owns it, on a valid/ready response port.
//   Only one request is in flight at a time.
//
// Parameters
//   PASS_MAX  max rotate steps per spinner pass (1..3)
//   CNT_W     width of the request rotate count
//
// Ports
//   clock, reset                 single clock; synchronous active-high reset
//   reqN_valid/ready/data/count  requester N (N=0,1) valid/ready request port
//   rsp_valid/ready/data/id      response port (rotated word + owner id)
//   sp_din/sp_amount/sp_spin     drive the spinner
//   sp_dout                      spinner result
//   busy                         high whenever a request is in flight
// -----------------------------------------------------------------------------
module spin_sequencer #(
   parameter int PASS_MAX = 3,
   parameter int CNT_W    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_data,
   input  logic [CNT_W-1:0] req0_count,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_data,
   input  logic [CNT_W-1:0] req1_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_data,
   output logic             rsp_id,
   output logic [3:0]       sp_din,
   output logic [1:0]       sp_amount,
   output logic             sp_spin,
   input  logic [3:0]       sp_dout,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, LOAD, ROT, RES, RSP} state_t;

   typedef struct packed {
      logic [3:0]       data;
      logic [CNT_W-1:0] count;
   } req_t;

   localparam logic [CNT_W-1:0] PASS_MAX_C = CNT_W'(PASS_MAX);
   localparam logic [1:0]       PASS_MAX_A = 2'(PASS_MAX);

   state_t           state;
   logic             rr;          // side that wins a tie: 0 -> req0, 1 -> req1
   logic [CNT_W-1:0] remaining;   // rotate steps not yet issued to the spinner
   logic             own_id;      // requester of the in-flight request
   logic             grant0, grant1, accept;
   req_t             req_sel;
   logic [1:0]       pass_amt;
   logic             more;

   // ---------------------------------------------------------------------------
   // Arbiter: a lone requester always wins; on a tie the rr pointer decides.
   // The grants are mutually exclusive by construction, so both readies can
   // never be high together.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant0 = req0_valid & (~req1_valid | ~rr);
      grant1 = req1_valid & (~req0_valid |  rr);
   end

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;
   assign accept     = req0_ready | req1_ready;
   assign busy       = (state != IDLE);

   always_comb begin
      if (grant1) begin
         req_sel.data  = req1_data;
         req_sel.count = req1_count;
      end else begin
         req_sel.data  = req0_data;
         req_sel.count = req0_count;
      end
   end

   // ---------------------------------------------------------------------------
   // Next pass size. It is min(remaining, PASS_MAX). "more" is set when steps
   // are still left after this pass. A zero count still gives one pass of
   // amount 0, so the word makes one trip through the spinner.
   // ---------------------------------------------------------------------------
   always_comb begin
      if (remaining >= PASS_MAX_C) pass_amt = PASS_MAX_A;
      else                         pass_amt = remaining[1:0];
      more = (remaining > PASS_MAX_C);
   end

   // ---------------------------------------------------------------------------
   // Sequencer FSM. All outputs are registered and are loaded on the edge that
   // enters the state that needs them. Example: sp_din is loaded on accept so
   // it is valid throughout LOAD, and it then holds until the next accept.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         rr        <= 1'b0;
         remaining <= '0;
         own_id    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 4'd0;
         rsp_id    <= 1'b0;
         sp_din    <= 4'd0;
         sp_amount <= 2'd0;
         sp_spin   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state     <= LOAD;
                  remaining <= req_sel.count;
                  own_id    <= grant1;
                  sp_din    <= req_sel.data;
                  rr        <= ~grant1;  // the other side wins the next tie
               end
            end
            LOAD: begin
               // The spinner samples sp_din into its input register this cycle
               // (its spin latch is clear), so the first pass can start now.
               state     <= ROT;
               sp_amount <= pass_amt;
               sp_spin   <= more;
            end
            ROT: begin
               state     <= RES;
               remaining <= remaining - CNT_W'(sp_amount);
               sp_amount <= 2'd0;
               sp_spin   <= 1'b0;
            end
            RES: begin
               if (remaining != '0) begin
                  // The spin issued in the previous ROT makes the spinner load
                  // this pass result as its new input.
                  state     <= ROT;
                  sp_amount <= pass_amt;
                  sp_spin   <= more;
               end else begin
                  state     <= RSP;
                  rsp_data  <= sp_dout;
                  rsp_id    <= own_id;
                  rsp_valid <= 1'b1;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
